bw_io_ddr_lane_seq: RTL
=======================

# bw_io_ddr_lane_seq

Parametrised DDR byte-lane sequencer: one write-burst FSM drives the DQ/DQS output-enable, strobe-enable and double-data-rate data registers for `DQ_W` data bits; a read capture FIFO buffers pad-side positive/negative samples for the core. It sits between the DRAM controller core and the per-bit DQ/DQS pad cells. It generalises the fixed 4-bit lane with these additions:
- width and FIFO-depth parameters;
- BL4/BL8 sequencing with seamless back-to-back bursts;
- sticky overflow/underflow error reporting.

## Interface
- `DQ_W`, 4: data bits per lane (1..16).
- `FIFO_DEPTH`, 4: read FIFO entries; power of two, 2..16.
- `rclk` in 1: lane clock, all state on rising edge.
- `arst_l` in 1: reset, asynchronous assert, active-low.
- `burst_length_four` in 1: 1 = BL4 (2 beats), 0 = BL8 (4 beats); sampled only when a burst is accepted.
- `dram_io_channel_disabled` in 1: synchronous abort/hold of the write path.
- `wr_start` in 1: request a write burst.
- `wr_busy` out 1: write FSM not IDLE.
- `wr_data_rd` out 1: core must present beat data this cycle.
- `data_pos`, `data_neg` in DQ_W: beat data, sampled when `wr_data_rd`=1.
- `dq_pos_out`, `dq_neg_out` out DQ_W: registered data to DQ pads.
- `dq_oe` out 1: DQ output enable.
- `dqs_oe` out 1: DQS output enable (preamble..postamble).
- `dqs_clk_en` out 1: DQS toggles this cycle.
- `rd_cap_valid` in 1: pad-side capture strobe.
- `rd_cap_pos`, `rd_cap_neg` in DQ_W: captured rise/fall samples.
- `rd_pop` in 1: core consumes FIFO head.
- `rd_valid` out 1: FIFO not empty.
- `io_dram_data_in`, `io_dram_data_in_hi` out DQ_W: FIFO head, rise/fall halves.
- `err_clr` in 1: clears sticky flags.
- `rd_overflow`, `rd_underflow` out 1: sticky error flags.

## Operation
- All outputs reset to 0. FSM resets to IDLE. FIFO pointers and count reset to 0.
- B = 2 (BL4) or 4 (BL8), latched into `bl_q` on acceptance.
- Write FSM states and transitions:
  - IDLE → PRE when `wr_start`=1 and channel enabled.
  - PRE → DATA after 1 cycle; beat counter = 0.
  - DATA: counter increments each cycle. On the last beat (counter = B-1):
    - if `wr_start`=1: seamless restart. Re-latch B, counter = 0, stay DATA (no POST/PRE).
    - otherwise → POST.
  - POST → IDLE after 1 cycle. `wr_start` in PRE or POST, or in DATA before the last beat, is ignored (no queueing).
- `wr_data_rd` = PRE, or DATA with counter < B-1, or DATA last beat with an accepted restart. Data is therefore fetched one cycle ahead.
- When `wr_data_rd`=1, `dq_pos_out`/`dq_neg_out` load `data_pos`/`data_neg`; otherwise they hold.
- Registered decodes:
  - `dq_oe` = state is DATA.
  - `dqs_clk_en` = state is DATA.
  - `dqs_oe` = state is PRE, DATA or POST.
- `dram_io_channel_disabled`=1 forces IDLE next edge from any state. `dq_oe`/`dqs_oe` drop the same edge. `wr_start` is ignored while it is 1.
- Read FIFO behaviour:
  - Push {pos,neg} on `rd_cap_valid`; first-word-fall-through head on the outputs; pop on `rd_pop`&&`rd_valid`.
  - Full+push without pop: push dropped, `rd_overflow` set.
  - Full+push+pop: both occur, no error.
  - Empty+pop: ignored, `rd_underflow` set.
  - Empty+push+pop: push accepted, pop ignored, `rd_underflow` set.
  - Pointers wrap modulo `FIFO_DEPTH`. Count width is clog2(FIFO_DEPTH)+1.
  - `err_clr` clears both flags. If a new error occurs in the same cycle, set wins.
  - Head outputs hold their last value when empty.

## Timing
- `wr_start` accepted at edge E0 → PRE in cycle 1; `dqs_oe`=1 and `wr_data_rd`=1 in cycle 1.
- DATA cycles: 2..B+1. `dq_oe`=`dqs_clk_en`=1, with beat k data on outputs in cycle 2+k.
- POST: cycle B+2. IDLE and `dqs_oe`=0 from cycle B+3.
- Total burst occupancy: B+2 cycles (BL4 = 4, BL8 = 6).
- A seamless second burst adds exactly B DATA cycles, with no gap in `dq_oe`.
- FIFO: push at edge E → `rd_valid`=1 and head data valid after E (1-cycle latency). Pop takes effect at the next edge.
- `arst_l` low mid-burst: outputs go 0 immediately (asynchronous); FIFO contents are discarded.

## Structure
- Package `bw_io_ddr_pkg` holds:
  - write-state enum (IDLE/PRE/DATA/POST);
  - beat constants BEATS_BL4=2, BEATS_BL8=4;
  - the beat counter width.
- Sub-module `bw_io_ddr_rd_fifo`, parameterised by width (2*DQ_W) and depth, contains the pointers, count and flags. The top holds the write FSM and output registers.

## Test plan
- BL4, DQ_W=4: `wr_start` with beats 0xA/0x5 then 0x3/0xC. Expect:
  - `wr_data_rd` in cycles 1–2;
  - `dq_oe` in cycles 2–3 with pos=A,neg=5 then pos=3,neg=C;
  - `dqs_oe` in cycles 1–4, IDLE at cycle 5.
- BL8 followed by `wr_start` on the last beat (BL4): `dq_oe` high for 6 contiguous cycles, no PRE/POST between bursts, `dqs_oe` high for 8 cycles.
- `dram_io_channel_disabled` pulsed in DATA beat 1 of a BL8 burst: next edge gives IDLE, `dq_oe`=`dqs_oe`=0; a `wr_start` during disable is ignored.
- FIFO_DEPTH=4: push 5 samples without pop. Expect:
  - the 5th is dropped and `rd_overflow`=1;
  - pops return the first 4 in order;
  - a 5th pop sets `rd_underflow`.
- Full FIFO with simultaneous push+pop: count stays 4, no overflow; wrap-around order preserved over 10 entries.
- `arst_l` asserted mid-BL8 with 2 FIFO entries: all outputs 0 asynchronously, `rd_valid`=0, flags cleared, a new burst works after release.

Source files
------------

// File: rtl/bw_io_ddr_pkg.sv
// Shared types and constants for the DDR byte-lane sequencer.
// Holds the write-path state encoding, burst beat counts and beat-counter width.
package bw_io_ddr_pkg;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_PRE  = 2'd1,
        WR_DATA = 2'd2,
        WR_POST = 2'd3
    } wr_state_e;

    localparam int unsigned BEATS_BL4  = 2;
    localparam int unsigned BEATS_BL8  = 4;
    localparam int unsigned BEAT_CNT_W = $clog2(BEATS_BL8);
    // Wide enough to hold the beat count itself (4), not just the index.
    localparam int unsigned BL_W       = BEAT_CNT_W + 1;

    // Beat count for the burst length requested at acceptance.
    function automatic logic [BL_W-1:0] burst_beats(input logic bl4);
        return bl4 ? BL_W'(BEATS_BL4) : BL_W'(BEATS_BL8);
    endfunction

endpackage

// File: rtl/bw_io_ddr_rd_fifo.sv
// Read capture FIFO, first-word-fall-through, with sticky overflow/underflow flags.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   push, wdata      : write request and payload
//   pop              : consume head (ignored when empty)
//   err_clr          : clear sticky flags (a new error in the same cycle wins)
//   valid, head      : registered not-empty flag and head entry (head holds when empty)
//   overflow         : sticky, set by push into a full FIFO without a pop
//   underflow        : sticky, set by pop while empty
module bw_io_ddr_rd_fifo
    import bw_io_ddr_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             err_clr,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_n;
    logic [WIDTH-1:0] head_n;
    logic             empty, full, pop_ok, push_ok, ovf_set, unf_set;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push && (!full || pop_ok);
    assign ovf_set = push && full && !pop_ok;
    assign unf_set = pop && empty;

    assign count_n = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);

    // Next head: the following stored entry on pop, or the incoming word when
    // the FIFO is (or becomes) empty; otherwise hold.
    always_comb begin
        head_n = head;
        if (pop_ok && (count_q > CNT_W'(1))) begin
            head_n = mem[rd_ptr_q + PTR_W'(1)];
        end else if (push_ok && (empty || pop_ok)) begin
            head_n = wdata;
        end
    end

    // Storage array, no reset needed: contents are only observed via head.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointers, count, head and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            valid     <= 1'b0;
            head      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q   <= count_n;
            valid     <= (count_n != '0);
            head      <= head_n;
            overflow  <= ovf_set || (overflow && !err_clr);
            underflow <= unf_set || (underflow && !err_clr);
        end
    end

endmodule

// File: rtl/bw_io_ddr_lane_seq.sv
// DDR byte-lane sequencer: write-burst FSM driving DQ/DQS enables and DDR data
// registers, plus a read capture FIFO toward the core.
// Ports:
//   rclk, arst_l                      : lane clock, async active-low reset
//   burst_length_four                 : 1 = BL4 (2 beats), 0 = BL8 (4 beats)
//   dram_io_channel_disabled          : synchronous abort/hold of the write path
//   wr_start                          : write burst request
//   wr_busy                           : write FSM not idle
//   wr_data_rd                        : core presents beat data this cycle (combinational)
//   data_pos, data_neg                : beat data from core
//   dq_pos_out, dq_neg_out            : registered DDR data to DQ pads
//   dq_oe, dqs_oe, dqs_clk_en         : pad enables
//   rd_cap_valid, rd_cap_pos/neg      : pad-side read capture
//   rd_pop, rd_valid                  : FIFO consume / not-empty
//   io_dram_data_in, io_dram_data_in_hi : FIFO head rise/fall halves
//   err_clr, rd_overflow, rd_underflow: sticky FIFO error flags
module bw_io_ddr_lane_seq
    import bw_io_ddr_pkg::*;
#(
    parameter int unsigned DQ_W       = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic            rclk,
    input  logic            arst_l,
    input  logic            burst_length_four,
    input  logic            dram_io_channel_disabled,
    input  logic            wr_start,
    output logic            wr_busy,
    output logic            wr_data_rd,
    input  logic [DQ_W-1:0] data_pos,
    input  logic [DQ_W-1:0] data_neg,
    output logic [DQ_W-1:0] dq_pos_out,
    output logic [DQ_W-1:0] dq_neg_out,
    output logic            dq_oe,
    output logic            dqs_oe,
    output logic            dqs_clk_en,
    input  logic            rd_cap_valid,
    input  logic [DQ_W-1:0] rd_cap_pos,
    input  logic [DQ_W-1:0] rd_cap_neg,
    input  logic            rd_pop,
    output logic            rd_valid,
    output logic [DQ_W-1:0] io_dram_data_in,
    output logic [DQ_W-1:0] io_dram_data_in_hi,
    input  logic            err_clr,
    output logic            rd_overflow,
    output logic            rd_underflow
);

    localparam int unsigned FIFO_W = 2 * DQ_W;

    wr_state_e              state_q, state_n;
    logic [BEAT_CNT_W-1:0]  beat_q, beat_n;
    logic [BL_W-1:0]        bl_q, bl_n;
    logic                   last_beat, start_ok, wr_data_rd_c;
    logic [FIFO_W-1:0]      fifo_head;

    assign start_ok  = wr_start && !dram_io_channel_disabled;
    assign last_beat = (BL_W'(beat_q) == (bl_q - BL_W'(1)));

    // Data is fetched one cycle ahead of the beat, so the seamless-restart
    // fetch depends on this cycle's wr_start and cannot be registered.
    assign wr_data_rd = wr_data_rd_c;

    // Write FSM next-state and data-fetch decode.
    always_comb begin
        state_n      = state_q;
        beat_n       = beat_q;
        bl_n         = bl_q;
        wr_data_rd_c = 1'b0;
        unique case (state_q)
            WR_IDLE: begin
                if (start_ok) begin
                    state_n = WR_PRE;
                    bl_n    = burst_beats(burst_length_four);
                end
            end
            WR_PRE: begin
                wr_data_rd_c = 1'b1;
                state_n      = WR_DATA;
                beat_n       = '0;
            end
            WR_DATA: begin
                if (!last_beat) begin
                    wr_data_rd_c = 1'b1;
                    beat_n       = beat_q + BEAT_CNT_W'(1);
                end else if (start_ok) begin
                    // Seamless back-to-back burst: no POST/PRE in between.
                    wr_data_rd_c = 1'b1;
                    bl_n         = burst_beats(burst_length_four);
                    beat_n       = '0;
                end else begin
                    state_n = WR_POST;
                end
            end
            WR_POST: begin
                state_n = WR_IDLE;
            end
            default: begin
                state_n = WR_IDLE;
            end
        endcase
        if (dram_io_channel_disabled) begin
            state_n = WR_IDLE;
        end
    end

    // State register and registered pad decodes (taken from next state so
    // they line up with the state they describe).
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state_q    <= WR_IDLE;
            beat_q     <= '0;
            bl_q       <= '0;
            wr_busy    <= 1'b0;
            dq_oe      <= 1'b0;
            dqs_oe     <= 1'b0;
            dqs_clk_en <= 1'b0;
            dq_pos_out <= '0;
            dq_neg_out <= '0;
        end else begin
            state_q    <= state_n;
            beat_q     <= beat_n;
            bl_q       <= bl_n;
            wr_busy    <= (state_n != WR_IDLE);
            dq_oe      <= (state_n == WR_DATA);
            dqs_clk_en <= (state_n == WR_DATA);
            dqs_oe     <= (state_n != WR_IDLE);
            if (wr_data_rd_c) begin
                dq_pos_out <= data_pos;
                dq_neg_out <= data_neg;
            end
        end
    end

    // Read capture FIFO; rise sample in the upper half of each entry.
    bw_io_ddr_rd_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rd_fifo (
        .clk       (rclk),
        .rst_n     (arst_l),
        .push      (rd_cap_valid),
        .wdata     ({rd_cap_pos, rd_cap_neg}),
        .pop       (rd_pop),
        .err_clr   (err_clr),
        .valid     (rd_valid),
        .head      (fifo_head),
        .overflow  (rd_overflow),
        .underflow (rd_underflow)
    );

    assign io_dram_data_in    = fifo_head[FIFO_W-1:DQ_W];
    assign io_dram_data_in_hi = fifo_head[DQ_W-1:0];

endmodule
